// File: rtl/motoro3_ramp_ctrl.sv
// Speed/direction sequencer for motoro3_top: ramps m3freq in fixed steps,
// forces a full ramp-down plus dead-time before a direction change, and
// drops the bridge on estop from any state.
module motoro3_ramp_ctrl #(
    parameter logic [9:0]  FREQ_MIN  = 10'd10,
    parameter logic [9:0]  FREQ_STEP = 10'd5,
    parameter logic [23:0] STEP_DIV  = 24'd1_000_000,
    parameter logic [23:0] DEAD_CYC  = 24'd5_000_000
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       cmdRun,
    input  logic       cmdRev,
    input  logic       estop,
    input  logic [9:0] targetFreq,
    output logic       m3start,
    output logic       m3invOrStop,
    output logic [9:0] m3freq,
    output logic       atSpeed,
    output logic       busy,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StRamp = 3'd1,
        StRun  = 3'd2,
        StDown = 3'd3,
        StDead = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [23:0] presc_q, presc_d;
    logic [23:0] dead_q, dead_d;
    logic        start_q, start_d;
    logic        inv_q, inv_d;
    logic [9:0]  freq_q, freq_d;
    logic        at_q, at_d;
    logic        busy_q, busy_d;

    // 11-bit working copies so sums and differences never wrap
    logic [10:0] freq_w, step_w, min_w, tgt_w;
    logic [10:0] up_next, dn_next, ramp_next, down_next;
    logic [23:0] presc_inc;
    logic        step_fire, stop_req;

    assign freq_w    = {1'b0, freq_q};
    assign step_w    = {1'b0, FREQ_STEP};
    assign min_w     = {1'b0, FREQ_MIN};
    assign tgt_w     = ({1'b0, targetFreq} < min_w) ? min_w : {1'b0, targetFreq};
    assign up_next   = (freq_w + step_w >= tgt_w) ? tgt_w : freq_w + step_w;
    assign dn_next   = (freq_w >= tgt_w + step_w) ? freq_w - step_w : tgt_w;
    assign ramp_next = (freq_w < tgt_w) ? up_next : dn_next;
    assign down_next = (freq_w >= min_w + step_w) ? freq_w - step_w : min_w;
    assign step_fire = (presc_q == STEP_DIV - 24'd1);
    assign presc_inc = step_fire ? 24'd0 : presc_q + 24'd1;
    // Stop on run drop or on a direction request differing from the latched one
    assign stop_req  = !cmdRun || (cmdRev != inv_q);

    // Next-state and next-output logic; estop overrides everything last
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        dead_d  = dead_q;
        start_d = start_q;
        inv_d   = inv_q;
        freq_d  = freq_q;
        case (state_q)
            StIdle: begin
                start_d = 1'b0;
                freq_d  = 10'd0;
                if (cmdRun && ({1'b0, targetFreq} >= min_w)) begin
                    start_d = 1'b1;
                    freq_d  = FREQ_MIN;
                    inv_d   = cmdRev;
                    presc_d = 24'd0;
                    state_d = StRamp;
                end
            end
            StRamp: begin
                if (stop_req) begin
                    presc_d = 24'd0;
                    state_d = StDown;
                end else if (freq_w == tgt_w) begin
                    state_d = StRun;
                end else begin
                    presc_d = presc_inc;
                    if (step_fire) begin
                        freq_d = ramp_next[9:0];
                        if (ramp_next == tgt_w) begin
                            state_d = StRun;
                        end
                    end
                end
            end
            StRun: begin
                if (stop_req) begin
                    presc_d = 24'd0;
                    state_d = StDown;
                end else if (tgt_w != freq_w) begin
                    presc_d = 24'd0;
                    state_d = StRamp;
                end
            end
            StDown: begin
                if (!stop_req) begin
                    presc_d = 24'd0;
                    state_d = StRamp;
                end else begin
                    presc_d = presc_inc;
                    if (step_fire) begin
                        if (freq_q == FREQ_MIN) begin
                            start_d = 1'b0;
                            freq_d  = 10'd0;
                            dead_d  = 24'd0;
                            state_d = StDead;
                        end else begin
                            freq_d = down_next[9:0];
                        end
                    end
                end
            end
            StDead: begin
                if (dead_q == DEAD_CYC - 24'd1) begin
                    dead_d  = 24'd0;
                    state_d = StIdle;
                end else begin
                    dead_d = dead_q + 24'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        if (estop) begin
            start_d = 1'b0;
            freq_d  = 10'd0;
            dead_d  = 24'd0;
            presc_d = 24'd0;
            state_d = StDead;
        end
        at_d   = (state_d == StRun);
        busy_d = (state_d != StIdle);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q <= StIdle;
            presc_q <= 24'd0;
            dead_q  <= 24'd0;
            start_q <= 1'b0;
            inv_q   <= 1'b0;
            freq_q  <= 10'd0;
            at_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            dead_q  <= dead_d;
            start_q <= start_d;
            inv_q   <= inv_d;
            freq_q  <= freq_d;
            at_q    <= at_d;
            busy_q  <= busy_d;
        end
    end

    assign m3start     = start_q;
    assign m3invOrStop = inv_q;
    assign m3freq      = freq_q;
    assign atSpeed     = at_q;
    assign busy        = busy_q;
    assign state       = state_q;

endmodule

// File: tb/tb_motoro3_ramp_ctrl.sv
// Directed bench for motoro3_ramp_ctrl with FREQ_MIN=10, FREQ_STEP=5,
// STEP_DIV=4, DEAD_CYC=8. Expected outputs are queued per cycle and checked
// #1 after the rising edge.
`timescale 1ns / 1ps
module tb_motoro3_ramp_ctrl;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RAMP = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_DOWN = 3'd3;
    localparam logic [2:0] S_DEAD = 3'd4;

    logic       clk = 1'b0;
    logic       nRst = 1'b0;
    logic       cmdRun = 1'b0;
    logic       cmdRev = 1'b0;
    logic       estop = 1'b0;
    logic [9:0] targetFreq = 10'd0;
    logic       m3start;
    logic       m3invOrStop;
    logic [9:0] m3freq;
    logic       atSpeed;
    logic       busy;
    logic [2:0] state;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        string      tag;
        logic [2:0] st;
        logic       s;
        logic       inv;
        logic [9:0] f;
    } exp_t;

    exp_t sb[$];

    motoro3_ramp_ctrl #(
        .FREQ_MIN (10'd10),
        .FREQ_STEP(10'd5),
        .STEP_DIV (24'd4),
        .DEAD_CYC (24'd8)
    ) dut (
        .clk        (clk),
        .nRst       (nRst),
        .cmdRun     (cmdRun),
        .cmdRev     (cmdRev),
        .estop      (estop),
        .targetFreq (targetFreq),
        .m3start    (m3start),
        .m3invOrStop(m3invOrStop),
        .m3freq     (m3freq),
        .atSpeed    (atSpeed),
        .busy       (busy),
        .state      (state)
    );

    always #50 clk = ~clk;

    task automatic push(input string tag, input logic [2:0] st, input logic s,
                        input logic inv, input logic [9:0] f);
        exp_t e;
        e.tag = tag;
        e.st  = st;
        e.s   = s;
        e.inv = inv;
        e.f   = f;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [16:0] obs;
        logic [16:0] expv;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            vectors++;
            obs  = {state, m3start, m3invOrStop, m3freq, atSpeed, busy};
            expv = {e.st, e.s, e.inv, e.f, (e.st == S_RUN), (e.st != S_IDLE)};
            assert (obs === expv) else begin
                miscompares++;
                $error("FAIL %s: observed st=%0d start=%0b inv=%0b freq=%0d at=%0b busy=%0b, expected st=%0d start=%0b inv=%0b freq=%0d at=%0b busy=%0b",
                       e.tag, state, m3start, m3invOrStop, m3freq, atSpeed, busy,
                       e.st, e.s, e.inv, e.f, (e.st == S_RUN), (e.st != S_IDLE));
            end
        end
    endtask

    // Expect these outputs after the next rising edge
    task automatic expect_cyc(input string tag, input logic [2:0] st, input logic s,
                              input logic inv, input logic [9:0] f);
        push(tag, st, s, inv, f);
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic check_now(input string tag, input logic [2:0] st, input logic s,
                             input logic inv, input logic [9:0] f);
        push(tag, st, s, inv, f);
        drain();
    endtask

    // One step period: three cycles holding the old value, then the new one
    task automatic hold_then(input string tag, input logic [2:0] st_h, input logic inv,
                             input logic [9:0] f_h, input logic [2:0] st_n,
                             input logic s_n, input logic [9:0] f_n);
        for (int i = 0; i < 3; i++) expect_cyc({tag, "_hold"}, st_h, 1'b1, inv, f_h);
        expect_cyc({tag, "_step"}, st_n, s_n, inv, f_n);
    endtask

    task automatic dead_then_idle(input string tag, input logic inv);
        for (int i = 0; i < 7; i++) expect_cyc({tag, "_dead"}, S_DEAD, 1'b0, inv, 10'd0);
        expect_cyc({tag, "_idle"}, S_IDLE, 1'b0, inv, 10'd0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_now("reset", S_IDLE, 1'b0, 1'b0, 10'd0);
        nRst = 1'b1;
        expect_cyc("idle0", S_IDLE, 1'b0, 1'b0, 10'd0);
        expect_cyc("idle1", S_IDLE, 1'b0, 1'b0, 10'd0);

        // Start and ramp to 30
        cmdRun = 1'b1;
        targetFreq = 10'd30;
        expect_cyc("start", S_RAMP, 1'b1, 1'b0, 10'd10);
        hold_then("up15", S_RAMP, 1'b0, 10'd10, S_RAMP, 1'b1, 10'd15);
        hold_then("up20", S_RAMP, 1'b0, 10'd15, S_RAMP, 1'b1, 10'd20);
        hold_then("up25", S_RAMP, 1'b0, 10'd20, S_RAMP, 1'b1, 10'd25);
        hold_then("up30", S_RAMP, 1'b0, 10'd25, S_RUN, 1'b1, 10'd30);
        expect_cyc("run30", S_RUN, 1'b1, 1'b0, 10'd30);

        // Stop: ramp down, dead-time, idle
        cmdRun = 1'b0;
        expect_cyc("stop", S_DOWN, 1'b1, 1'b0, 10'd30);
        hold_then("dn25", S_DOWN, 1'b0, 10'd30, S_DOWN, 1'b1, 10'd25);
        hold_then("dn20", S_DOWN, 1'b0, 10'd25, S_DOWN, 1'b1, 10'd20);
        hold_then("dn15", S_DOWN, 1'b0, 10'd20, S_DOWN, 1'b1, 10'd15);
        hold_then("dn10", S_DOWN, 1'b0, 10'd15, S_DOWN, 1'b1, 10'd10);
        hold_then("off", S_DOWN, 1'b0, 10'd10, S_DEAD, 1'b0, 10'd0);
        dead_then_idle("stop", 1'b0);
        expect_cyc("idle_stay", S_IDLE, 1'b0, 1'b0, 10'd0);

        // Clamp at 32, then retarget down to 21 and 20
        cmdRun = 1'b1;
        targetFreq = 10'd32;
        expect_cyc("c_start", S_RAMP, 1'b1, 1'b0, 10'd10);
        hold_then("c15", S_RAMP, 1'b0, 10'd10, S_RAMP, 1'b1, 10'd15);
        hold_then("c20", S_RAMP, 1'b0, 10'd15, S_RAMP, 1'b1, 10'd20);
        hold_then("c25", S_RAMP, 1'b0, 10'd20, S_RAMP, 1'b1, 10'd25);
        hold_then("c30", S_RAMP, 1'b0, 10'd25, S_RAMP, 1'b1, 10'd30);
        hold_then("c32", S_RAMP, 1'b0, 10'd30, S_RUN, 1'b1, 10'd32);
        expect_cyc("run32", S_RUN, 1'b1, 1'b0, 10'd32);
        targetFreq = 10'd21;
        expect_cyc("retgt", S_RAMP, 1'b1, 1'b0, 10'd32);
        hold_then("r27", S_RAMP, 1'b0, 10'd32, S_RAMP, 1'b1, 10'd27);
        hold_then("r22", S_RAMP, 1'b0, 10'd27, S_RAMP, 1'b1, 10'd22);
        hold_then("r21", S_RAMP, 1'b0, 10'd22, S_RUN, 1'b1, 10'd21);
        targetFreq = 10'd20;
        expect_cyc("retgt20", S_RAMP, 1'b1, 1'b0, 10'd21);
        hold_then("r20", S_RAMP, 1'b0, 10'd21, S_RUN, 1'b1, 10'd20);

        // Reverse: ramp down, dead-time, restart reversed
        cmdRev = 1'b1;
        expect_cyc("rev", S_DOWN, 1'b1, 1'b0, 10'd20);
        hold_then("rv15", S_DOWN, 1'b0, 10'd20, S_DOWN, 1'b1, 10'd15);
        hold_then("rv10", S_DOWN, 1'b0, 10'd15, S_DOWN, 1'b1, 10'd10);
        hold_then("rvoff", S_DOWN, 1'b0, 10'd10, S_DEAD, 1'b0, 10'd0);
        dead_then_idle("rev", 1'b0);
        expect_cyc("rev_start", S_RAMP, 1'b1, 1'b1, 10'd10);
        hold_then("rvu15", S_RAMP, 1'b1, 10'd10, S_RAMP, 1'b1, 10'd15);

        // Run drops and returns during DOWN: ramp back up with no dead-time
        cmdRun = 1'b0;
        expect_cyc("dn_enter", S_DOWN, 1'b1, 1'b1, 10'd15);
        expect_cyc("dn_wait", S_DOWN, 1'b1, 1'b1, 10'd15);
        cmdRun = 1'b1;
        expect_cyc("dn_back", S_RAMP, 1'b1, 1'b1, 10'd15);
        hold_then("back20", S_RAMP, 1'b1, 10'd15, S_RUN, 1'b1, 10'd20);

        // Emergency stop mid-step, held, then released
        targetFreq = 10'd30;
        expect_cyc("e_ramp", S_RAMP, 1'b1, 1'b1, 10'd20);
        hold_then("e25", S_RAMP, 1'b1, 10'd20, S_RAMP, 1'b1, 10'd25);
        expect_cyc("e_mid", S_RAMP, 1'b1, 1'b1, 10'd25);
        estop = 1'b1;
        expect_cyc("estop", S_DEAD, 1'b0, 1'b1, 10'd0);
        for (int i = 0; i < 20; i++) expect_cyc("estop_hold", S_DEAD, 1'b0, 1'b1, 10'd0);
        estop = 1'b0;
        dead_then_idle("erel", 1'b1);

        // estop coinciding with a start request in IDLE wins
        estop = 1'b1;
        expect_cyc("e_vs_start", S_DEAD, 1'b0, 1'b1, 10'd0);
        estop = 1'b0;
        dead_then_idle("erel2", 1'b1);
        expect_cyc("e_restart", S_RAMP, 1'b1, 1'b1, 10'd10);
        expect_cyc("e_ramp2", S_RAMP, 1'b1, 1'b1, 10'd10);

        // Asynchronous reset mid-ramp
        nRst = 1'b0;
        #1;
        check_now("async_rst", S_IDLE, 1'b0, 1'b0, 10'd0);
        cmdRun = 1'b0;
        cmdRev = 1'b0;
        #2;
        nRst = 1'b1;
        for (int i = 0; i < 3; i++) expect_cyc("post_rst", S_IDLE, 1'b0, 1'b0, 10'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
